// File: rtl/reg_file_sb.sv
// Parametrised register file with a per-register pending scoreboard for outstanding loads.
// Optional: define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module reg_file_sb #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 3,
   parameter int ZERO_REG = 0
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              WRITE,
   input  logic [DATA_W-1:0] IN,
   input  logic [ADDR_W-1:0] INADDRESS,
   input  logic [ADDR_W-1:0] OUT1ADDRESS,
   input  logic [ADDR_W-1:0] OUT2ADDRESS,
   output logic [DATA_W-1:0] OUT1,
   output logic [DATA_W-1:0] OUT2,
   input  logic              busywait,
   input  logic              RESERVE,
   input  logic [ADDR_W-1:0] RSVADDRESS,
   output logic              HAZARD1,
   output logic              HAZARD2,
   output logic [ADDR_W:0]   PEND_CNT
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DEPTH-1:0]  pend_q, pend_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic              wr_en, rsv_en;

   function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
      logic [ADDR_W:0] c;
      c = '0;
      for (int i = 0; i < DEPTH; i++) c = c + {{ADDR_W{1'b0}}, v[i]};
      return c;
   endfunction

   assign wr_en  = WRITE   && !busywait && !RESET && !is_zero_reg(INADDRESS);
   assign rsv_en = RESERVE && !busywait && !RESET && !is_zero_reg(RSVADDRESS);

   // Reserve is applied after the write so a same-edge load to the written register stays pending.
   always_comb begin
      pend_d = pend_q;
      if (wr_en)  pend_d[INADDRESS]  = 1'b0;
      if (rsv_en) pend_d[RSVADDRESS] = 1'b1;
      cnt_d = popcount(pend_d);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
         pend_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (wr_en) regs_q[INADDRESS] <= IN;
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
      end
   end

   always_comb begin
      OUT1    = is_zero_reg(OUT1ADDRESS) ? '0 : regs_q[OUT1ADDRESS];
      OUT2    = is_zero_reg(OUT2ADDRESS) ? '0 : regs_q[OUT2ADDRESS];
      HAZARD1 = pend_q[OUT1ADDRESS];
      HAZARD2 = pend_q[OUT2ADDRESS];
`ifdef REGFILE_BYPASS_EN
      // Forwarded data is current, so only a same-cycle reserve keeps the port hazarded.
      if (wr_en && (INADDRESS == OUT1ADDRESS)) begin
         OUT1    = IN;
         HAZARD1 = rsv_en && (RSVADDRESS == OUT1ADDRESS);
      end
      if (wr_en && (INADDRESS == OUT2ADDRESS)) begin
         OUT2    = IN;
         HAZARD2 = rsv_en && (RSVADDRESS == OUT2ADDRESS);
      end
`endif
   end

   assign PEND_CNT = cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed scenarios then random traffic, two instances (ZERO_REG 0 and 1).
module tb_reg_file_sb;

   logic       CLK;
   logic       RESET;
   logic       WRITE;
   logic [7:0] IN;
   logic [2:0] INADDRESS, OUT1ADDRESS, OUT2ADDRESS, RSVADDRESS;
   logic       busywait, RESERVE;

   logic [7:0] OUT1_0, OUT2_0, OUT1_1, OUT2_1;
   logic       H1_0, H2_0, H1_1, H2_1;
   logic [3:0] CNT_0, CNT_1;

   int checks = 0;
   int passed = 0;
   int fails  = 0;

   // Reference state: [instance][register]
   logic [7:0] mem  [2][8];
   bit         pend [2][8];

   reg_file_sb #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0)) dut0 (
      .CLK(CLK), .RESET(RESET), .WRITE(WRITE), .IN(IN), .INADDRESS(INADDRESS),
      .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .OUT1(OUT1_0), .OUT2(OUT2_0),
      .busywait(busywait), .RESERVE(RESERVE), .RSVADDRESS(RSVADDRESS),
      .HAZARD1(H1_0), .HAZARD2(H2_0), .PEND_CNT(CNT_0));

   reg_file_sb #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1)) dut1 (
      .CLK(CLK), .RESET(RESET), .WRITE(WRITE), .IN(IN), .INADDRESS(INADDRESS),
      .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .OUT1(OUT1_1), .OUT2(OUT2_1),
      .busywait(busywait), .RESERVE(RESERVE), .RSVADDRESS(RSVADDRESS),
      .HAZARD1(H1_1), .HAZARD2(H2_1), .PEND_CNT(CNT_1));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int z = 0; z < 2; z++)
         for (int r = 0; r < 8; r++) begin
            mem[z][r]  = 8'h00;
            pend[z][r] = 1'b0;
         end
   endtask

   task automatic model_edge();
      bit zr;
      if (RESET) return;
      for (int z = 0; z < 2; z++) begin
         zr = (z == 1);
         if (WRITE && !busywait && !(zr && INADDRESS == 3'd0)) begin
            mem[z][INADDRESS]  = IN;
            pend[z][INADDRESS] = 1'b0;
         end
         if (RESERVE && !busywait && !(zr && RSVADDRESS == 3'd0))
            pend[z][RSVADDRESS] = 1'b1;
      end
   endtask

   function automatic logic [7:0] exp_out(input int z, input logic [2:0] a);
      if (z == 1 && a == 3'd0) return 8'h00;
`ifdef REGFILE_BYPASS_EN
      if (!RESET && WRITE && !busywait && INADDRESS == a) return IN;
`endif
      return mem[z][a];
   endfunction

   function automatic logic exp_haz(input int z, input logic [2:0] a);
      if (z == 1 && a == 3'd0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
      if (!RESET && WRITE && !busywait && INADDRESS == a)
         return RESERVE && (RSVADDRESS == a);
`endif
      return pend[z][a];
   endfunction

   function automatic int exp_cnt(input int z);
      int n = 0;
      for (int r = 0; r < 8; r++) n += int'(pend[z][r]);
      return n;
   endfunction

   task automatic check_all(input string tag);
      check({tag, "_out1_z0"}, 32'(OUT1_0), 32'(exp_out(0, OUT1ADDRESS)));
      check({tag, "_out2_z0"}, 32'(OUT2_0), 32'(exp_out(0, OUT2ADDRESS)));
      check({tag, "_haz1_z0"}, 32'(H1_0),   32'(exp_haz(0, OUT1ADDRESS)));
      check({tag, "_haz2_z0"}, 32'(H2_0),   32'(exp_haz(0, OUT2ADDRESS)));
      check({tag, "_cnt_z0"},  32'(CNT_0),  32'(exp_cnt(0)));
      check({tag, "_out1_z1"}, 32'(OUT1_1), 32'(exp_out(1, OUT1ADDRESS)));
      check({tag, "_out2_z1"}, 32'(OUT2_1), 32'(exp_out(1, OUT2ADDRESS)));
      check({tag, "_haz1_z1"}, 32'(H1_1),   32'(exp_haz(1, OUT1ADDRESS)));
      check({tag, "_haz2_z1"}, 32'(H2_1),   32'(exp_haz(1, OUT2ADDRESS)));
      check({tag, "_cnt_z1"},  32'(CNT_1),  32'(exp_cnt(1)));
   endtask

   // Inputs change 1 time unit after the edge; comparisons happen 1 unit later still.
   task automatic settle(input string tag);
      #1;
      check_all({tag, "_pre"});
   endtask

   task automatic step(input string tag);
      @(posedge CLK);
      model_edge();
      #1;
      check_all({tag, "_post"});
   endtask

   task automatic idle();
      WRITE = 1'b0; RESERVE = 1'b0; busywait = 1'b0;
   endtask

   initial begin
      RESET = 1'b1; WRITE = 1'b0; IN = 8'h00; INADDRESS = 3'd0;
      OUT1ADDRESS = 3'd3; OUT2ADDRESS = 3'd5; busywait = 1'b0;
      RESERVE = 1'b0; RSVADDRESS = 3'd0;
      model_reset();
      #12;
      check_all("rst_held");
      check("rst_cnt", 32'(CNT_0), 32'd0);
      RESET = 1'b0;
      settle("rst_rel");

      // Write reg3 then reset mid-cycle; also hold reset across an edge with a write pending.
      WRITE = 1'b1; IN = 8'h5A; INADDRESS = 3'd3; RESERVE = 1'b1; RSVADDRESS = 3'd1;
      step("t1_wr");
      idle();
      settle("t1_rd");
      check("t1_before_rst", 32'(OUT1_0), 32'h5A);
      RESET = 1'b1;
      model_reset();
      #1;
      check("t1_out1_async", 32'(OUT1_0), 32'h00);
      check("t1_cnt_async",  32'(CNT_0),  32'd0);
      check_all("t1_async");
      WRITE = 1'b1; IN = 8'hEE; RESERVE = 1'b1;
      step("t1_held");
      check("t1_held_out1", 32'(OUT1_0), 32'h00);
      RESET = 1'b0;
      idle();
      settle("t1_rel");

      // busywait blocks a write for three edges.
      WRITE = 1'b1; IN = 8'h10; INADDRESS = 3'd5;
      step("t2_old");
      IN = 8'hC3; busywait = 1'b1; OUT2ADDRESS = 3'd5;
      settle("t2_bw");
      for (int i = 0; i < 3; i++) begin
         step("t2_stall");
         check("t2_hold", 32'(OUT2_0), 32'h10);
      end
      busywait = 1'b0;
      settle("t2_go");
      step("t2_edge");
      idle();
      settle("t2_rd");
      check("t2_new", 32'(OUT2_0), 32'hC3);

      // Reserve then write clears the hazard.
      RESERVE = 1'b1; RSVADDRESS = 3'd2; OUT1ADDRESS = 3'd2;
      step("t3_rsv");
      idle();
      settle("t3_rsv_rd");
      check("t3_haz_set", 32'(H1_0),  32'd1);
      check("t3_cnt_one", 32'(CNT_0), 32'd1);
      WRITE = 1'b1; IN = 8'h11; INADDRESS = 3'd2;
      step("t3_wr");
      idle();
      settle("t3_wr_rd");
      check("t3_haz_clr", 32'(H1_0),   32'd0);
      check("t3_cnt_zero", 32'(CNT_0), 32'd0);
      check("t3_out1",    32'(OUT1_0), 32'h11);

      // Same-edge write and reserve to an already pending register.
      RESERVE = 1'b1; RSVADDRESS = 3'd4; OUT1ADDRESS = 3'd4;
      step("t4_rsv");
      WRITE = 1'b1; IN = 8'h77; INADDRESS = 3'd4;
      settle("t4_both");
      step("t4_edge");
      idle();
      settle("t4_rd");
      check("t4_data", 32'(OUT1_0), 32'h77);
      check("t4_haz",  32'(H1_0),   32'd1);
      check("t4_cnt",  32'(CNT_0),  32'd1);

      // Read-during-write visibility.
      WRITE = 1'b1; IN = 8'h21; INADDRESS = 3'd6;
      step("t5_old");
      IN = 8'h9E; OUT1ADDRESS = 3'd6;
      #1;
`ifdef REGFILE_BYPASS_EN
      check("t5_before_edge", 32'(OUT1_0), 32'h9E);
`else
      check("t5_before_edge", 32'(OUT1_0), 32'h21);
`endif
      check_all("t5_pre");
      step("t5_edge");
      idle();
      settle("t5_rd");
      check("t5_after_edge", 32'(OUT1_0), 32'h9E);

      // Hardwired zero register on the ZERO_REG=1 instance.
      RESET = 1'b1;
      model_reset();
      #1;
      RESET = 1'b0;
      WRITE = 1'b1; IN = 8'hFF; INADDRESS = 3'd0;
      RESERVE = 1'b1; RSVADDRESS = 3'd0; OUT1ADDRESS = 3'd0;
      settle("t6_pre");
      step("t6_edge");
      idle();
      settle("t6_rd");
      check("t6_z1_out1", 32'(OUT1_1), 32'h00);
      check("t6_z1_haz1", 32'(H1_1),   32'd0);
      check("t6_z1_cnt",  32'(CNT_1),  32'd0);
      check("t6_z0_out1", 32'(OUT1_0), 32'hFF);
      check("t6_z0_cnt",  32'(CNT_0),  32'd1);

      // Random traffic with occasional asynchronous reset pulses.
      for (int n = 0; n < 300; n++) begin
         WRITE       = ($urandom % 2) == 0;
         RESERVE     = ($urandom % 3) == 0;
         busywait    = ($urandom % 5) == 0;
         IN          = 8'($urandom);
         INADDRESS   = 3'($urandom);
         RSVADDRESS  = 3'($urandom);
         OUT1ADDRESS = 3'($urandom);
         OUT2ADDRESS = ($urandom % 4 == 0) ? OUT1ADDRESS : 3'($urandom);
         if (($urandom % 60) == 0) begin
            RESET = 1'b1;
            model_reset();
            #1;
            check_all("rnd_rst");
            RESET = 1'b0;
         end
         settle("rnd");
         step("rnd");
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
